// File: rtl/btn_cond.sv
// Multi-channel push-button conditioner: 2-flop sync, tick-based debounce,
// registered level / press / release outputs with per-channel hold-to-repeat.
module btn_cond #(
    parameter int unsigned N          = 3,
    parameter int unsigned DEB_MS     = 20,
    parameter int unsigned REP_DLY_MS = 500,
    parameter int unsigned REP_MS     = 100,
    parameter logic [N-1:0] REP_EN    = {N{1'b1}}
) (
    input  logic         clk,
    input  logic         R,
    input  logic         ce,
    input  logic [N-1:0] BTN,
    output logic [N-1:0] LVL,
    output logic [N-1:0] PRESS,
    output logic [N-1:0] REL
);

    localparam int unsigned CW = 10;
    localparam logic [CW-1:0] DEB_TOP = CW'(DEB_MS - 1);
    localparam logic [CW-1:0] DLY_TOP = CW'(REP_DLY_MS - 1);
    localparam logic [CW-1:0] REP_TOP = CW'(REP_MS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic          s1_q, s0_q;
        logic          lvl_q, lvl_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic [CW-1:0] dc_q, dc_d;
        logic [CW-1:0] rc_q, rc_d;
        state_e        state_q, state_d;
        logic          acc_c;
        logic          rep_c;

        always_ff @(posedge clk or negedge R) begin
            if (!R) begin
                s1_q    <= 1'b0;
                s0_q    <= 1'b0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                dc_q    <= '0;
                rc_q    <= '0;
                state_q <= IDLE;
            end else begin
                s1_q    <= BTN[g];
                s0_q    <= s1_q;
                lvl_q   <= lvl_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                dc_q    <= dc_d;
                rc_q    <= rc_d;
                state_q <= state_d;
            end
        end

        // Debounce plus repeat FSM; an accepted release always beats a repeat pulse.
        always_comb begin
            lvl_d   = lvl_q;
            dc_d    = dc_q;
            rc_d    = rc_q;
            state_d = state_q;
            acc_c   = 1'b0;
            rep_c   = 1'b0;
            press_d = 1'b0;
            rel_d   = 1'b0;

            if (s0_q == lvl_q) begin
                dc_d = '0;
            end else if (ce) begin
                if (dc_q == DEB_TOP) begin
                    lvl_d = s0_q;
                    dc_d  = '0;
                    acc_c = 1'b1;
                end else begin
                    dc_d = dc_q + CW'(1);
                end
            end

            case (state_q)
                IDLE: begin
                    if (acc_c && s0_q) begin
                        state_d = DELAY;
                        rc_d    = '0;
                    end
                end
                DELAY: begin
                    if (acc_c) begin
                        state_d = IDLE;
                        rc_d    = '0;
                    end else if (ce && REP_EN[g]) begin
                        if (rc_q == DLY_TOP) begin
                            rep_c   = 1'b1;
                            rc_d    = '0;
                            state_d = REPEAT;
                        end else begin
                            rc_d = rc_q + CW'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (acc_c) begin
                        state_d = IDLE;
                        rc_d    = '0;
                    end else if (ce) begin
                        if (rc_q == REP_TOP) begin
                            rep_c = 1'b1;
                            rc_d  = '0;
                        end else begin
                            rc_d = rc_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    rc_d    = '0;
                end
            endcase

            press_d = (acc_c && s0_q) || rep_c;
            rel_d   = acc_c && !s0_q;
        end

        assign LVL[g]   = lvl_q;
        assign PRESS[g] = press_q;
        assign REL[g]   = rel_q;
    end

endmodule

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: directed vector table, test-plan sequences, and random
// stimulus checked every cycle against a tick-arithmetic reference model.
module tb_btn_cond;

    localparam int unsigned N    = 3;
    localparam int unsigned DEB  = 20;
    localparam int unsigned RDLY = 500;
    localparam int unsigned RMS  = 100;
    localparam logic [2:0]  REPEN = 3'b110;

    logic       clk = 1'b0;
    logic       R;
    logic       ce;
    logic [2:0] BTN;
    logic [2:0] LVL, PRESS, REL;

    btn_cond #(
        .N(N), .DEB_MS(DEB), .REP_DLY_MS(RDLY), .REP_MS(RMS), .REP_EN(REPEN)
    ) dut (
        .clk(clk), .R(R), .ce(ce), .BTN(BTN), .LVL(LVL), .PRESS(PRESS), .REL(REL)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: counts ce ticks in a disagreement run, and decides
    // repeats from the tick distance since the accepted press.
    logic [2:0] m_s1, m_s0, m_lvl, m_press, m_rel;
    int m_run[3];
    int m_ptick[3];
    int m_tick = 0;

    task automatic model_reset();
        m_s1 = '0; m_s0 = '0; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int i = 0; i < 3; i++) begin
            m_run[i]   = 0;
            m_ptick[i] = 0;
        end
    endtask

    function automatic bit is_rep(input int d);
        return (d == int'(RDLY)) || (d > int'(RDLY) && ((d - int'(RDLY)) % int'(RMS)) == 0);
    endfunction

    task automatic model_clock(input logic [2:0] b, input logic c);
        logic [2:0] np = '0;
        logic [2:0] nr = '0;
        logic       rep;
        if (c) m_tick++;
        for (int i = 0; i < 3; i++) begin
            rep = c && m_lvl[i] && REPEN[i] && is_rep(m_tick - m_ptick[i]);
            if (m_s0[i] == m_lvl[i]) begin
                m_run[i] = 0;
            end else if (c) begin
                m_run[i]++;
                if (m_run[i] == int'(DEB)) begin
                    m_lvl[i] = m_s0[i];
                    m_run[i] = 0;
                    if (m_s0[i]) begin
                        np[i]      = 1'b1;
                        m_ptick[i] = m_tick;
                    end else begin
                        nr[i] = 1'b1;
                    end
                end
            end
            np[i] = np[i] | (rep & ~nr[i]);
        end
        m_press = np;
        m_rel   = nr;
        m_s0    = m_s1;
        m_s1    = b;
    endtask

    // Observed DUT activity within the current sequence phase
    int obs_press[3], obs_rel[3], obs_lvl[3], first_pt[3], first_rt[3];
    int q2[$];
    int seq_tick;

    task automatic clear_obs();
        for (int i = 0; i < 3; i++) begin
            obs_press[i] = 0; obs_rel[i] = 0; obs_lvl[i] = 0;
            first_pt[i] = -1; first_rt[i] = -1;
        end
        q2.delete();
        seq_tick = 0;
    endtask

    task automatic step(input logic [2:0] b, input logic c);
        BTN = b;
        ce  = c;
        @(posedge clk);
        model_clock(b, c);
        #1;
        chk("lvl", LVL, m_lvl);
        chk("press", PRESS, m_press);
        chk("rel", REL, m_rel);
        if (c) seq_tick++;
        for (int i = 0; i < 3; i++) begin
            if (PRESS[i]) begin
                obs_press[i]++;
                if (first_pt[i] < 0) first_pt[i] = seq_tick;
                if (i == 2) q2.push_back(seq_tick);
            end
            if (REL[i]) begin
                obs_rel[i]++;
                if (first_rt[i] < 0) first_rt[i] = seq_tick;
            end
            if (LVL[i]) obs_lvl[i]++;
        end
    endtask

    // One 1 ms tick: ce strobes on every fourth clk
    task automatic ms(input logic [2:0] b, input int n);
        repeat (n) begin
            step(b, 1'b0); step(b, 1'b0); step(b, 1'b0); step(b, 1'b1);
        end
    endtask

    typedef struct {
        logic [2:0] btn;
        logic       c;
        int         n;
        logic [2:0] lvl;
        logic [2:0] press;
        logic [2:0] rel;
    } vec_t;

    vec_t vt[15];
    logic [2:0] rb;

    initial begin
        vt[0]  = '{3'b001, 1'b1, 21, 3'b000, 3'b000, 3'b000};
        vt[1]  = '{3'b001, 1'b1,  1, 3'b001, 3'b001, 3'b000};
        vt[2]  = '{3'b001, 1'b1,  1, 3'b001, 3'b000, 3'b000};
        vt[3]  = '{3'b000, 1'b1, 21, 3'b001, 3'b000, 3'b000};
        vt[4]  = '{3'b000, 1'b1,  1, 3'b000, 3'b000, 3'b001};
        vt[5]  = '{3'b000, 1'b1,  1, 3'b000, 3'b000, 3'b000};
        vt[6]  = '{3'b010, 1'b0, 30, 3'b000, 3'b000, 3'b000};
        vt[7]  = '{3'b010, 1'b1, 19, 3'b000, 3'b000, 3'b000};
        vt[8]  = '{3'b010, 1'b1,  1, 3'b010, 3'b010, 3'b000};
        vt[9]  = '{3'b000, 1'b1, 21, 3'b010, 3'b000, 3'b000};
        vt[10] = '{3'b000, 1'b1,  1, 3'b000, 3'b000, 3'b010};
        vt[11] = '{3'b111, 1'b1, 21, 3'b000, 3'b000, 3'b000};
        vt[12] = '{3'b111, 1'b1,  1, 3'b111, 3'b111, 3'b000};
        vt[13] = '{3'b000, 1'b1, 21, 3'b111, 3'b000, 3'b000};
        vt[14] = '{3'b000, 1'b1,  1, 3'b000, 3'b000, 3'b111};

        R = 1'b1; ce = 1'b0; BTN = '0;
        model_reset();
        clear_obs();
        #2 R = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset lvl", LVL, 3'b000);
        chk("reset press", PRESS, 3'b000);
        chk("reset rel", REL, 3'b000);
        R = 1'b1;

        // Directed vector table, ce every clk
        for (int k = 0; k < 15; k++) begin
            repeat (vt[k].n) step(vt[k].btn, vt[k].c);
            chk($sformatf("vec%0d lvl", k), LVL, vt[k].lvl);
            chk($sformatf("vec%0d press", k), PRESS, vt[k].press);
            chk($sformatf("vec%0d rel", k), REL, vt[k].rel);
        end
        ms(3'b000, 5);

        // Clean press on channel 0
        clear_obs();
        ms(3'b001, 40);
        chk_int("clean press cnt", obs_press[0], 1);
        chk_int("clean press tick", first_pt[0], 20);
        chk("clean lvl", LVL, 3'b001);
        clear_obs();
        ms(3'b000, 30);
        chk_int("clean rel cnt", obs_rel[0], 1);
        chk_int("clean rel tick", first_rt[0], 20);
        chk_int("clean other bits", obs_press[1] + obs_press[2] + obs_rel[1] + obs_rel[2], 0);

        // Bounce on channel 1: 3 ms phases never reach the stable time
        clear_obs();
        for (int k = 0; k < 10; k++) ms((k % 2 == 0) ? 3'b010 : 3'b000, 3);
        ms(3'b000, 30);
        chk_int("bounce lvl", obs_lvl[1], 0);
        chk_int("bounce press", obs_press[1], 0);
        chk_int("bounce rel", obs_rel[1], 0);

        // Auto-repeat on channel 2
        clear_obs();
        ms(3'b100, 800);
        chk_int("repeat cnt", obs_press[2], 4);
        chk_int("repeat q size", q2.size(), 4);
        if (q2.size() == 4) begin
            chk_int("repeat t0", q2[0], 20);
            chk_int("repeat t1", q2[1], 520);
            chk_int("repeat t2", q2[2], 620);
            chk_int("repeat t3", q2[3], 720);
        end
        clear_obs();
        ms(3'b000, 40);
        chk_int("repeat rel cnt", obs_rel[2], 1);
        chk_int("repeat after rel", obs_press[2], 0);

        // Channel 0 has repeat disabled
        clear_obs();
        ms(3'b001, 800);
        chk_int("norep press cnt", obs_press[0], 1);
        clear_obs();
        ms(3'b000, 30);
        chk_int("norep rel cnt", obs_rel[0], 1);

        // Reset while channel 0 is held
        clear_obs();
        ms(3'b001, 300);
        chk("pre-reset lvl", LVL, 3'b001);
        #2 R = 1'b0;
        #1;
        chk("async rst lvl", LVL, 3'b000);
        chk("async rst press", PRESS, 3'b000);
        chk("async rst rel", REL, 3'b000);
        model_reset();
        repeat (5) @(posedge clk);
        #1 R = 1'b1;
        clear_obs();
        ms(3'b001, 40);
        chk_int("post-rst press cnt", obs_press[0], 1);
        chk_int("post-rst press tick", first_pt[0], 20);
        chk_int("post-rst no rel", obs_rel[0], 0);
        ms(3'b000, 30);

        // ce stalled while channel 1 is held
        clear_obs();
        repeat (200) step(3'b010, 1'b0);
        chk_int("stall lvl", obs_lvl[1], 0);
        chk_int("stall press", obs_press[1], 0);
        clear_obs();
        ms(3'b010, 25);
        chk_int("unstall press cnt", obs_press[1], 1);
        chk_int("unstall press tick", first_pt[1], 20);
        ms(3'b000, 30);

        // Random stimulus with slow button changes and random ce
        rb = '0;
        for (int k = 0; k < 20000; k++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 49) == 0) rb[i] = ~rb[i];
            step(rb, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
